multicycle_controller: RTL and testbench

//  Sequencing FSM for the multi-cycle RV32I core: one ALU and one unified instruction/data memory
//  are shared across cycles. Per state it drives datapath muxes, register-write enables and the

---
 rtl/multicycle_controller_pkg.sv | 70 +++++++
 rtl/multicycle_controller_if.sv | 32 +++
 rtl/multicycle_controller_alu_dec.sv | 35 +++
 rtl/multicycle_controller.sv | 155 +++++++++++++++
 tb/tb_multicycle_controller.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multi-cycle RV32I sequencing controller:
// FSM states, opcodes, ALUOp classes, datapath select codes and ALU control codes.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_LUI,
    S_TRAP
  } state_e;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;  // constant 0 operand, used by LUI

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [2:0] EXT_I = 3'b000;
  localparam logic [2:0] EXT_S = 3'b001;
  localparam logic [2:0] EXT_B = 3'b010;
  localparam logic [2:0] EXT_J = 3'b011;
  localparam logic [2:0] EXT_U = 3'b100;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_SLL  = 4'h2;
  localparam logic [3:0] ALU_SLT  = 4'h3;
  localparam logic [3:0] ALU_SLTU = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_OR   = 4'h8;
  localparam logic [3:0] ALU_AND  = 4'h9;

  // States that hold a memory request open and therefore count wait cycles.
  function automatic logic is_mem_state(state_e s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle: instruction fields and status in, control out.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       sel_adr;
  logic       ir_we;
  logic       pc_we;
  logic       rf_we;
  logic [1:0] sel_alu_src_a;
  logic [1:0] sel_alu_src_b;
  logic [2:0] sel_ext;
  logic [1:0] sel_result;
  logic [3:0] alu_control;
  logic       trap;

  modport master (
    input  op, funct3, funct7, zero, mem_ready,
    output mem_req, mem_we, sel_adr, ir_we, pc_we, rf_we, sel_alu_src_a, sel_alu_src_b,
           sel_ext, sel_result, alu_control, trap
  );

  modport slave (
    output op, funct3, funct7, zero, mem_ready,
    input  mem_req, mem_we, sel_adr, ir_we, pc_we, rf_we, sel_alu_src_a, sel_alu_src_b,
           sel_ext, sel_result, alu_control, trap
  );
endinterface

// File: rtl/multicycle_controller_alu_dec.sv
// ALU decoder: maps the controller's ALUOp class plus funct3/funct7 to an ALU control code.
module multicycle_controller_alu_dec
  import multicycle_controller_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_control
);

  logic alt;
  assign alt = (funct7 == 7'b0100000);

  always_comb begin
    alu_control = ALU_ADD;
    unique case (alu_op)
      ALU_OP_ADD: alu_control = ALU_ADD;
      ALU_OP_SUB: alu_control = ALU_SUB;
      ALU_OP_FUNCT: begin
        unique case (funct3)
          3'b000: alu_control = alt ? ALU_SUB : ALU_ADD;
          3'b001: alu_control = ALU_SLL;
          3'b010: alu_control = ALU_SLT;
          3'b011: alu_control = ALU_SLTU;
          3'b100: alu_control = ALU_XOR;
          3'b101: alu_control = alt ? ALU_SRA : ALU_SRL;
          3'b110: alu_control = ALU_OR;
          3'b111: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I core: drives datapath selects, write enables and the
// shared memory request per state, with a bus-wait timeout and a sticky trap state.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter state_e      RESET_STATE = S_FETCH,
  parameter int unsigned WAIT_MAX    = 255
) (
  input logic                     clk,
  input logic                     rst,
  multicycle_controller_if.master ctrl
);

  localparam int unsigned CntW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  alu_op_e         alu_op;
  logic [6:0]      funct7_dec;
  logic            branch_ok;
  logic            take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RESET_STATE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign branch_ok = (ctrl.funct3[2:1] == 2'b00);
  assign take      = ctrl.funct3[0] ? ~ctrl.zero : ctrl.zero;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    unique case (state_q)
      S_FETCH:    if (ctrl.mem_ready) state_d = S_DECODE;
      S_MEMREAD:  if (ctrl.mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (ctrl.mem_ready) state_d = S_FETCH;
      S_DECODE: begin
        unique case (ctrl.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:                     state_d = (ctrl.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_EXEC_R, S_EXEC_I, S_JAL, S_LUI: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB:             state_d = S_FETCH;
      S_BRANCH:                     state_d = branch_ok ? S_FETCH : S_TRAP;
      S_TRAP:                       state_d = S_TRAP;
      default:                      state_d = S_TRAP;
    endcase
    // Counter only advances while a request is stalled; any state change leaves it cleared.
    if (is_mem_state(state_q) && !ctrl.mem_ready && (WAIT_MAX != 0)) begin
      if (wait_cnt_q == CntW'(WAIT_MAX)) state_d = S_TRAP;
      else wait_cnt_d = wait_cnt_q + CntW'(1);
    end
  end

  always_comb begin
    ctrl.mem_req       = 1'b0;
    ctrl.mem_we        = 1'b0;
    ctrl.sel_adr       = 1'b0;
    ctrl.ir_we         = 1'b0;
    ctrl.pc_we         = 1'b0;
    ctrl.rf_we         = 1'b0;
    ctrl.sel_alu_src_a = SRC_A_PC;
    ctrl.sel_alu_src_b = SRC_B_RS2;
    ctrl.sel_ext       = EXT_I;
    ctrl.sel_result    = RES_ALUOUT;
    ctrl.trap          = 1'b0;
    alu_op             = ALU_OP_ADD;
    // Reset gates every output so a request in flight drops without waiting for a clock.
    if (!rst) begin
      unique case (state_q)
        S_FETCH: begin
          ctrl.mem_req       = 1'b1;
          ctrl.ir_we         = ctrl.mem_ready;
          ctrl.pc_we         = ctrl.mem_ready;
          ctrl.sel_alu_src_b = SRC_B_FOUR;
          ctrl.sel_result    = RES_ALU;
        end
        S_DECODE: begin
          ctrl.sel_alu_src_a = SRC_A_OLDPC;
          ctrl.sel_alu_src_b = SRC_B_IMM;
          ctrl.sel_ext       = (ctrl.op == OP_JAL) ? EXT_J : EXT_B;
        end
        S_MEMADR: begin
          ctrl.sel_alu_src_a = SRC_A_RS1;
          ctrl.sel_alu_src_b = SRC_B_IMM;
          ctrl.sel_ext       = (ctrl.op == OP_STORE) ? EXT_S : EXT_I;
        end
        S_MEMREAD: begin
          ctrl.mem_req = 1'b1;
          ctrl.sel_adr = 1'b1;
        end
        S_MEMWB: begin
          ctrl.rf_we      = 1'b1;
          ctrl.sel_result = RES_MEM;
        end
        S_MEMWRITE: begin
          ctrl.mem_req = 1'b1;
          ctrl.mem_we  = 1'b1;
          ctrl.sel_adr = 1'b1;
        end
        S_EXEC_R: begin
          ctrl.sel_alu_src_a = SRC_A_RS1;
          alu_op             = ALU_OP_FUNCT;
        end
        S_EXEC_I: begin
          ctrl.sel_alu_src_a = SRC_A_RS1;
          ctrl.sel_alu_src_b = SRC_B_IMM;
          alu_op             = ALU_OP_FUNCT;
        end
        S_ALUWB: ctrl.rf_we = 1'b1;
        S_BRANCH: begin
          ctrl.sel_alu_src_a = SRC_A_RS1;
          alu_op             = ALU_OP_SUB;
          ctrl.pc_we         = branch_ok & take;
        end
        S_JAL: begin
          ctrl.sel_alu_src_a = SRC_A_OLDPC;
          ctrl.sel_alu_src_b = SRC_B_FOUR;
          ctrl.pc_we         = 1'b1;
        end
        S_LUI: begin
          ctrl.sel_alu_src_a = SRC_A_ZERO;
          ctrl.sel_alu_src_b = SRC_B_IMM;
          ctrl.sel_ext       = EXT_U;
        end
        S_TRAP:  ctrl.trap = 1'b1;
        default: ctrl.trap = 1'b0;
      endcase
    end
  end

  // I-type funct7 bits are immediate data; only srai carries a real alternate-op bit there.
  assign funct7_dec = ((state_q == S_EXEC_I) && (ctrl.funct3 != 3'b101)) ? 7'b0 : ctrl.funct7;

  multicycle_controller_alu_dec u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (ctrl.funct3),
    .funct7      (funct7_dec),
    .alu_control (ctrl.alu_control)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle control vectors via a scoreboard,
// plus reset, trap, bus-timeout and mid-access reset sequences.
module tb_multicycle_controller;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       sel_adr;
    logic       ir_we;
    logic       pc_we;
    logic       rf_we;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] ext;
    logic [1:0] res;
    logic [3:0] alu;
    logic       trap;
  } ctl_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       zero;
    logic       rdy;
    ctl_t       exp;
  } vec_t;

  typedef struct {
    string name;
    ctl_t  exp;
  } sb_t;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_BAD = 7'b1111111;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;

  vec_t vecs[$];
  sb_t  sb_q[$];
  ctl_t act;

  multicycle_controller_if bus ();
  multicycle_controller_if bus_w ();

  multicycle_controller dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  multicycle_controller #(.WAIT_MAX(4)) dut_w (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus_w)
  );

  always #5 clk = ~clk;

  assign act = {bus.mem_req, bus.mem_we, bus.sel_adr, bus.ir_we, bus.pc_we, bus.rf_we,
                bus.sel_alu_src_a, bus.sel_alu_src_b, bus.sel_ext, bus.sel_result,
                bus.alu_control, bus.trap};

  function automatic ctl_t mk(input logic req, we, adr, ir, pc, rf, input logic [1:0] a, b,
                              input logic [2:0] ext, input logic [1:0] res,
                              input logic [3:0] alu, input logic trap);
    return {req, we, adr, ir, pc, rf, a, b, ext, res, alu, trap};
  endfunction

  function automatic void add(input string name, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic zero, rdy, input ctl_t exp);
    vec_t v;
    v.name = name; v.op = op; v.f3 = f3; v.f7 = f7; v.zero = zero; v.rdy = rdy; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Drive one cycle of inputs, queue its expected outputs, advance past the next rising edge.
  task automatic step(input vec_t v);
    sb_t s;
    bus.op = v.op; bus.funct3 = v.f3; bus.funct7 = v.f7;
    bus.zero = v.zero; bus.mem_ready = v.rdy;
    s.name = v.name; s.exp = v.exp;
    sb_q.push_back(s);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string name, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic zero, rdy, input ctl_t exp);
    vec_t v;
    v.name = name; v.op = op; v.f3 = f3; v.f7 = f7; v.zero = zero; v.rdy = rdy; v.exp = exp;
    step(v);
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    check({name, "_outputs"}, 32'(act), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    sb_t s;
    if (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      n_checks++;
      if (act !== s.exp) begin
        n_err++;
        $display("FAIL %s: got %05h expected %05h", s.name, act, s.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    ctl_t fe, fe_w, de, de_j, wb, ex_r, ex_i, ma_l, ma_s, mr, mwb, mw, tr;
    int   req_cycles;
    logic ir_seen, got_trap;

    fe   = mk(1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 3'd0, 2'b10, 4'h0, 0);
    fe_w = mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'd0, 2'b10, 4'h0, 0);
    de   = mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 3'd2, 2'b00, 4'h0, 0);
    de_j = mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 3'd3, 2'b00, 4'h0, 0);
    wb   = mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'd0, 2'b00, 4'h0, 0);
    ex_r = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 3'd0, 2'b00, 4'h0, 0);
    ex_i = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 3'd0, 2'b00, 4'h0, 0);
    ma_l = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 3'd0, 2'b00, 4'h0, 0);
    ma_s = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 3'd1, 2'b00, 4'h0, 0);
    mr   = mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'd0, 2'b00, 4'h0, 0);
    mwb  = mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'd0, 2'b01, 4'h0, 0);
    mw   = mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 3'd0, 2'b00, 4'h0, 0);
    tr   = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'd0, 2'b00, 4'h0, 1);

    bus.op = OP_R; bus.funct3 = 3'd0; bus.funct7 = 7'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    bus_w.op = OP_R; bus_w.funct3 = 3'd0; bus_w.funct7 = 7'd0; bus_w.zero = 1'b0;
    bus_w.mem_ready = 1'b0;

    add("fetch_wait", OP_R,   3'd0, 7'd0,   0, 0, fe_w);
    add("add_fetch",  OP_R,   3'd0, 7'd0,   0, 1, fe);
    add("add_decode", OP_R,   3'd0, 7'd0,   0, 1, de);
    add("add_exec",   OP_R,   3'd0, 7'd0,   0, 1, ex_r);
    add("add_wb",     OP_R,   3'd0, 7'd0,   0, 1, wb);
    add("sub_fetch",  OP_R,   3'd0, F7_ALT, 0, 1, fe);
    add("sub_decode", OP_R,   3'd0, F7_ALT, 0, 1, de);
    add("sub_exec",   OP_R,   3'd0, F7_ALT, 0, 1, ex_r | 20'h2);
    add("sub_wb",     OP_R,   3'd0, F7_ALT, 0, 1, wb);
    add("and_fetch",  OP_R,   3'd7, 7'd0,   0, 1, fe);
    add("and_decode", OP_R,   3'd7, 7'd0,   0, 1, de);
    add("and_exec",   OP_R,   3'd7, 7'd0,   0, 1, ex_r | 20'h12);
    add("and_wb",     OP_R,   3'd7, 7'd0,   0, 1, wb);
    add("lw_fetch",   OP_LD,  3'd2, 7'd0,   0, 1, fe);
    add("lw_decode",  OP_LD,  3'd2, 7'd0,   0, 1, de);
    add("lw_memadr",  OP_LD,  3'd2, 7'd0,   0, 1, ma_l);
    add("lw_wait1",   OP_LD,  3'd2, 7'd0,   0, 0, mr);
    add("lw_wait2",   OP_LD,  3'd2, 7'd0,   0, 0, mr);
    add("lw_wait3",   OP_LD,  3'd2, 7'd0,   0, 0, mr);
    add("lw_ready",   OP_LD,  3'd2, 7'd0,   0, 1, mr);
    add("lw_memwb",   OP_LD,  3'd2, 7'd0,   0, 1, mwb);
    add("beq_fetch",  OP_BR,  3'd0, 7'd0,   1, 1, fe);
    add("beq_decode", OP_BR,  3'd0, 7'd0,   1, 1, de);
    add("beq_taken",  OP_BR,  3'd0, 7'd0,   1, 1, mk(0,0,0,0,1,0,2'b10,2'b00,3'd0,2'b00,4'h1,0));
    add("bne_fetch",  OP_BR,  3'd1, 7'd0,   1, 1, fe);
    add("bne_decode", OP_BR,  3'd1, 7'd0,   1, 1, de);
    add("bne_not",    OP_BR,  3'd1, 7'd0,   1, 1, mk(0,0,0,0,0,0,2'b10,2'b00,3'd0,2'b00,4'h1,0));
    add("sw_fetch",   OP_ST,  3'd2, 7'd0,   0, 1, fe);
    add("sw_decode",  OP_ST,  3'd2, 7'd0,   0, 1, de);
    add("sw_memadr",  OP_ST,  3'd2, 7'd0,   0, 1, ma_s);
    add("sw_write",   OP_ST,  3'd2, 7'd0,   0, 1, mw);
    add("jal_fetch",  OP_JAL, 3'd0, 7'd0,   0, 1, fe);
    add("jal_decode", OP_JAL, 3'd0, 7'd0,   0, 1, de_j);
    add("jal_exec",   OP_JAL, 3'd0, 7'd0,   0, 1, mk(0,0,0,0,1,0,2'b01,2'b10,3'd0,2'b00,4'h0,0));
    add("jal_wb",     OP_JAL, 3'd0, 7'd0,   0, 1, wb);
    add("lui_fetch",  OP_LUI, 3'd0, 7'd0,   0, 1, fe);
    add("lui_decode", OP_LUI, 3'd0, 7'd0,   0, 1, de);
    add("lui_exec",   OP_LUI, 3'd0, 7'd0,   0, 1, mk(0,0,0,0,0,0,2'b11,2'b01,3'd4,2'b00,4'h0,0));
    add("lui_wb",     OP_LUI, 3'd0, 7'd0,   0, 1, wb);
    add("addi_fetch", OP_I,   3'd0, F7_ALT, 0, 1, fe);
    add("addi_decode", OP_I,  3'd0, F7_ALT, 0, 1, de);
    add("addi_exec",  OP_I,   3'd0, F7_ALT, 0, 1, ex_i);
    add("addi_wb",    OP_I,   3'd0, F7_ALT, 0, 1, wb);
    add("srai_fetch", OP_I,   3'd5, F7_ALT, 0, 1, fe);
    add("srai_decode", OP_I,  3'd5, F7_ALT, 0, 1, de);
    add("srai_exec",  OP_I,   3'd5, F7_ALT, 0, 1, ex_i | 20'he);
    add("srai_wb",    OP_I,   3'd5, F7_ALT, 0, 1, wb);

    do_reset("reset_initial");
    foreach (vecs[i]) step(vecs[i]);

    // Illegal opcode: trap after decode, sticky regardless of inputs.
    do_reset("reset_pre_illegal");
    run("ill_fetch",  OP_BAD, 3'd0, 7'd0, 0, 1, fe);
    run("ill_decode", OP_BAD, 3'd0, 7'd0, 0, 1, de);
    for (int i = 0; i < 3; i++) run("ill_trap", OP_R, 3'd0, 7'd0, 1, 1, tr);

    // Unsupported branch funct3 traps with no PC write.
    do_reset("reset_clears_trap");
    run("blt_fetch",  OP_BR, 3'd4, 7'd0, 0, 1, fe);
    run("blt_decode", OP_BR, 3'd4, 7'd0, 0, 1, de);
    run("blt_branch", OP_BR, 3'd4, 7'd0, 0, 1, mk(0,0,0,0,0,0,2'b10,2'b00,3'd0,2'b00,4'h1,0));
    run("blt_trap",   OP_BR, 3'd4, 7'd0, 0, 1, tr);

    // Reset in the middle of a stalled store.
    do_reset("reset_pre_store");
    run("rsw_fetch",  OP_ST, 3'd2, 7'd0, 0, 1, fe);
    run("rsw_decode", OP_ST, 3'd2, 7'd0, 0, 1, de);
    run("rsw_memadr", OP_ST, 3'd2, 7'd0, 0, 1, ma_s);
    run("rsw_stall",  OP_ST, 3'd2, 7'd0, 0, 0, mw);
    #2;
    check("rsw_req_before_rst", 32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("rsw_req_drop", 32'(bus.mem_req), 32'd0);
    check("rsw_we_drop", 32'(bus.mem_we), 32'd0);
    check("rsw_trap_clear", 32'(bus.trap), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run("rsw_refetch", OP_ST, 3'd2, 7'd0, 0, 0, fe_w);

    // Bus timeout on the WAIT_MAX=4 instance: memory never answers during fetch.
    bus_w.mem_ready = 1'b0;
    do_reset("reset_pre_timeout");
    req_cycles = 0;
    ir_seen = 1'b0;
    got_trap = 1'b0;
    for (int i = 0; i < 20 && !got_trap; i++) begin
      @(negedge clk);
      if (bus_w.trap) got_trap = 1'b1;
      else begin
        if (bus_w.mem_req) req_cycles++;
        if (bus_w.ir_we) ir_seen = 1'b1;
      end
    end
    check("timeout_trap", 32'(got_trap), 32'd1);
    check("timeout_req_cycles", 32'(req_cycles), 32'd5);
    check("timeout_no_ir_we", 32'(ir_seen), 32'd0);
    check("timeout_req_drop", 32'(bus_w.mem_req), 32'd0);
    bus_w.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("timeout_sticky", 32'(bus_w.trap), 32'd1);
    check("timeout_no_pc_we", 32'(bus_w.pc_we), 32'd0);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
